// File: rtl/cam_fifo_pkg.sv
// Shared constants and width helper for the camera-path synchronous FIFO.
package cam_fifo_pkg;

  localparam int ERR_OVER_BIT  = 0;
  localparam int ERR_UNDER_BIT = 1;

  // Occupancy needs one extra bit so that COUNT can reach DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cam_fifo_ram.sv
// Simple dual-port storage for cam_sync_fifo: one write port, one registered read port.
module cam_fifo_ram #(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is cleared; the array contents are don't-care after a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/cam_sync_fifo.sv
// Single-clock pixel FIFO with threshold flag, occupancy count and sticky error status.
// Optional PEAK occupancy output is enabled by defining CAM_SYNC_FIFO_PEAK_EN.
module cam_sync_fifo
  import cam_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 1024,
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  input  logic                  FIFORST,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  FIFOWR,
  input  logic                  FIFORD,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  FIFOVALID,
  input  logic [CNT_WIDTH-1:0]  THRESH,
  output logic                  HASDATA,
  output logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  BUF_OVER,
  output logic                  BUF_UNDER,
  output logic [1:0]            ERR_STICKY,
  input  logic                  ERR_CLR
`ifdef CAM_SYNC_FIFO_PEAK_EN
  ,
  output logic [CNT_WIDTH-1:0]  PEAK
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [AW-1:0]        wptr, rptr;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 wr_acc, rd_acc, over_ev, under_ev;
  logic [1:0]           err_set;

  // Flags derive from the registered count, so accept decisions see start-of-cycle state.
  assign COUNT   = count_q;
  assign FULL    = (count_q == DEPTH_C);
  assign EMPTY   = (count_q == '0);
  assign HASDATA = (count_q >= THRESH);

  assign wr_acc   = FIFOWR & ~FULL  & ~FIFORST;
  assign rd_acc   = FIFORD & ~EMPTY & ~FIFORST;
  assign over_ev  = FIFOWR & FULL   & ~FIFORST;
  assign under_ev = FIFORD & EMPTY  & ~FIFORST;

  always_comb begin
    err_set                = '0;
    err_set[ERR_OVER_BIT]  = over_ev;
    err_set[ERR_UNDER_BIT] = under_ev;
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      FIFOVALID <= 1'b0;
      BUF_OVER  <= 1'b0;
      BUF_UNDER <= 1'b0;
    end else if (FIFORST) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      FIFOVALID <= 1'b0;
      BUF_OVER  <= 1'b0;
      BUF_UNDER <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      FIFOVALID <= rd_acc;
      BUF_OVER  <= over_ev;
      BUF_UNDER <= under_ev;
    end
  end

  // Sticky status survives a flush; a new error in the clear cycle wins over the clear.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) ERR_STICKY <= '0;
    else      ERR_STICKY <= (ERR_STICKY & ~{2{ERR_CLR}}) | err_set;
  end

  cam_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (ACLK),
    .rst   (ARST),
    .clr   (FIFORST),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (WDATA),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (READDATA)
  );

`ifdef CAM_SYNC_FIFO_PEAK_EN
  logic [CNT_WIDTH-1:0] peak_q;

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST)                    peak_q <= '0;
    else if (FIFORST || ERR_CLR) peak_q <= '0;
    else if (count_q > peak_q)   peak_q <= count_q;
  end

  assign PEAK = peak_q;
`endif

endmodule

// File: tb/tb_cam_sync_fifo.sv
// Self-checking bench for cam_sync_fifo (DEPTH=16): directed plan plus randomized traffic vs a queue model.
module tb_cam_sync_fifo;

  localparam int DW    = 48;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          ACLK = 1'b0;
  logic          ARST, FIFORST, FIFOWR, FIFORD, ERR_CLR;
  logic [DW-1:0] WDATA;
  logic [CW-1:0] THRESH;
  logic [DW-1:0] READDATA;
  logic          FIFOVALID, HASDATA, FULL, EMPTY, BUF_OVER, BUF_UNDER;
  logic [CW-1:0] COUNT;
  logic [1:0]    ERR_STICKY;
`ifdef CAM_SYNC_FIFO_PEAK_EN
  logic [CW-1:0] PEAK;
`endif

  cam_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .FIFORST    (FIFORST),
    .WDATA      (WDATA),
    .FIFOWR     (FIFOWR),
    .FIFORD     (FIFORD),
    .READDATA   (READDATA),
    .FIFOVALID  (FIFOVALID),
    .THRESH     (THRESH),
    .HASDATA    (HASDATA),
    .COUNT      (COUNT),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .BUF_OVER   (BUF_OVER),
    .BUF_UNDER  (BUF_UNDER),
    .ERR_STICKY (ERR_STICKY),
    .ERR_CLR    (ERR_CLR)
`ifdef CAM_SYNC_FIFO_PEAK_EN
    ,
    .PEAK       (PEAK)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Reference model: the FIFO is just a queue of words plus a few flags.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rdata;
  logic          m_valid, m_over, m_under;
  logic [1:0]    m_err;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = '0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
    m_err   = 2'b00;
  endtask

  task automatic check_all();
    chk("count",     64'(COUNT),      64'(q.size()));
    chk("full",      64'(FULL),       64'(q.size() == DEPTH));
    chk("empty",     64'(EMPTY),      64'(q.size() == 0));
    chk("hasdata",   64'(HASDATA),    64'(q.size() >= int'(THRESH)));
    chk("fifovalid", 64'(FIFOVALID),  64'(m_valid));
    chk("readdata",  64'(READDATA),   64'(m_rdata));
    chk("buf_over",  64'(BUF_OVER),   64'(m_over));
    chk("buf_under", 64'(BUF_UNDER),  64'(m_under));
    chk("err",       64'(ERR_STICKY), 64'(m_err));
  endtask

  // One clock: drive inputs, advance the model from the pre-edge state, then compare.
  task automatic cyc(input logic wr, input logic rd, input logic frst, input logic clr,
                     input logic [DW-1:0] wd);
    bit wr_ok, rd_ok;
    FIFOWR = wr; FIFORD = rd; FIFORST = frst; ERR_CLR = clr; WDATA = wd;
    m_over  = wr && !frst && (q.size() == DEPTH);
    m_under = rd && !frst && (q.size() == 0);
    if (clr) m_err = 2'b00;
    m_err = m_err | {m_under, m_over};
    if (frst) begin
      q.delete();
      m_rdata = '0;
      m_valid = 1'b0;
    end else begin
      wr_ok = wr && (q.size() < DEPTH);
      rd_ok = rd && (q.size() > 0);
      if (rd_ok) m_rdata = q.pop_front();
      m_valid = rd_ok;
      if (wr_ok) q.push_back(wd);
    end
    @(posedge ACLK);
    #1;
    check_all();
  endtask

  initial begin
    ARST = 1'b1; FIFORST = 1'b0; FIFOWR = 1'b0; FIFORD = 1'b0; ERR_CLR = 1'b0;
    WDATA = '0; THRESH = 5'd8;
    model_reset();
    #1;
    check_all();
    chk("rst_empty", 64'(EMPTY), 64'd1);
    @(posedge ACLK); #1;
    ARST = 1'b0;

    // Threshold crossing at 8 words.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
      if (i == 7) chk("hasdata_at7", 64'(HASDATA), 64'd0);
    end
    chk("count_at8", 64'(COUNT), 64'd8);
    chk("hasdata_at8", 64'(HASDATA), 64'd1);

    // Fill, then one overflow attempt.
    for (int i = 9; i <= 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
    chk("full_at16", 64'(FULL), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(48'hDEAD));
    chk("over_pulse", 64'(BUF_OVER), 64'd1);
    chk("err_over", 64'(ERR_STICKY), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("over_one_cycle", 64'(BUF_OVER), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("readback", 64'(READDATA), 64'(i));
    end

    // Underflow, then clear.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("under_pulse", 64'(BUF_UNDER), 64'd1);
    chk("under_novalid", 64'(FIFOVALID), 64'd0);
    chk("err_under", 64'(ERR_STICKY[1]), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("err_cleared", 64'(ERR_STICKY), 64'd0);

    // Steady state at COUNT=5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(48'h100 + i));
    for (int i = 5; i < 45; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, DW'(48'h100 + i));
      chk("pass_valid", 64'(FIFOVALID), 64'd1);
      chk("pass_data", 64'(READDATA), 64'(48'h100 + i - 5));
    end
    chk("pass_count", 64'(COUNT), 64'd5);

    // Flush at COUNT=10 with a same-cycle write; sticky underflow must survive.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(48'h200 + i));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, DW'(48'hBEEF));
    chk("flush_count", 64'(COUNT), 64'd0);
    chk("flush_empty", 64'(EMPTY), 64'd1);
    chk("flush_noover", 64'(BUF_OVER), 64'd0);
    chk("flush_err", 64'(ERR_STICKY), 64'd2);

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      int bias;
      bias = ((i / 100) % 2 == 0) ? 75 : 30;
      if (i % 16 == 0) THRESH = CW'($urandom_range(0, 20));
      cyc(($urandom % 100) < bias, ($urandom % 100) < (100 - bias),
          ($urandom % 100) < 2, ($urandom % 100) < 3, {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a write burst.
    THRESH = 5'd8;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, DW'(48'h300 + i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(48'h400 + i));
    cyc(1'b1, 1'b1, 1'b0, 1'b1, DW'(48'h500));
    FIFOWR = 1'b1; FIFORD = 1'b1; WDATA = DW'(48'h501);
    #2;
    ARST = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_err", 64'(ERR_STICKY), 64'd0);
    FIFOWR = 1'b0; FIFORD = 1'b0;
    @(posedge ACLK); #1;
    check_all();
    ARST = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, DW'(48'hABCD_1234_5678));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("post_arst_data", 64'(READDATA), 64'(48'hABCD_1234_5678));
    chk("post_arst_valid", 64'(FIFOVALID), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_sync_fifo.md
Name: cam_sync_fifo

Overview:
- Parametrised single-clock successor to the camera-path pixel buffer.
- Buffers DATA_WIDTH-wide pixel words between the capture front end and the AXI master, both on ACLK.
- Adds a runtime-programmable data threshold, full/empty flags, a live occupancy count, sticky error status, and a synchronous flush.
- Read semantics are standard (non-FWFT): data appears one cycle after an accepted read, qualified by FIFOVALID.

Parameters:
- DATA_WIDTH, 48, word width in bits.
- DEPTH, 1024, number of entries; must be a power of two, minimum 4.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy and threshold buses; derived, do not override.

Ports:
- ACLK  in  1  clock.
- ARST  in  1  asynchronous active-high reset.
- FIFORST  in  1  synchronous flush, active-high.
- WDATA  in  DATA_WIDTH  write data.
- FIFOWR  in  1  write request.
- FIFORD  in  1  read request.
- READDATA  out  DATA_WIDTH  read data, valid when FIFOVALID=1.
- FIFOVALID  out  1  one-cycle qualifier for READDATA.
- THRESH  in  CNT_WIDTH  HASDATA threshold.
- HASDATA  out  1  COUNT >= THRESH.
- COUNT  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- BUF_OVER  out  1  one-cycle pulse: write rejected.
- BUF_UNDER  out  1  one-cycle pulse: read rejected.
- ERR_STICKY  out  2  bit0 = overflow seen, bit1 = underflow seen.
- ERR_CLR  in  1  clears ERR_STICKY.

Behaviour:
- Reset (ARST=1, async): pointers=0, COUNT=0, EMPTY=1, FULL=0, FIFOVALID=0, READDATA=0, BUF_OVER=0, BUF_UNDER=0, ERR_STICKY=0. HASDATA follows its comparison (1 only if THRESH=0).
- Write accept: FIFOWR & !FULL. FULL is the registered value at the start of the cycle; a write while FULL is rejected even if a read is accepted in the same cycle.
- Read accept: FIFORD & !EMPTY, also using registered EMPTY; a read while EMPTY is rejected even with a same-cycle write.
- Accepted write: RAM[wptr] <= WDATA; wptr increments modulo DEPTH.
- Accepted read: READDATA <= RAM[rptr] and FIFOVALID=1 on the next cycle; rptr increments modulo DEPTH. Read latency is 1.
- No accepted read: FIFOVALID=0 next cycle; READDATA holds its last value.
- COUNT is registered: +1 on write only, -1 on read only, unchanged on both or neither.
- FULL, EMPTY and COUNT update one cycle after the accepting edge.
- HASDATA is combinational from registered COUNT and the live THRESH input. THRESH > DEPTH means HASDATA is never asserted.
- Rejected write: data dropped, BUF_OVER=1 for one cycle, ERR_STICKY[0] set.
- Rejected read: BUF_UNDER=1 for one cycle, ERR_STICKY[1] set.
- Sticky bits hold until ERR_CLR. If ERR_CLR and a new error occur in the same cycle, the set wins.
- FIFORST (sync): next cycle has the same state as reset except ERR_STICKY, which is preserved. FIFOWR/FIFORD in a FIFORST cycle are ignored and raise no error pulses.
- Pointer wrap: pointers are AW=$clog2(DEPTH) bits and wrap silently; FULL/EMPTY come from COUNT, never from pointer comparison.

Optional Feature:
- Macro: CAM_SYNC_FIFO_PEAK_EN.
- With it defined: extra output PEAK (CNT_WIDTH bits) records the maximum COUNT since the last ARST, FIFORST or ERR_CLR, updated one cycle after COUNT.
- Without it: no PEAK port and no peak logic.

Decomposition:
- Package cam_fifo_pkg holds:
  - ERR_OVER_BIT=0 and ERR_UNDER_BIT=1
  - the clog2-based CNT_WIDTH derivation helper
- Sub-module cam_fifo_ram:
  - simple dual-port RAM, DATA_WIDTH x DEPTH
  - one write port, one registered read port
  - no reset on the array
  - read-data register reset to 0 via ARST

Test Plan:
- DEPTH=16, THRESH=8: write 8 words 0x1..0x8 -> COUNT=8, HASDATA=1 the cycle after the 8th write; HASDATA=0 after the 7th.
- Write 16 words, then a 17th (0xDEAD) -> FULL=1, BUF_OVER pulse once, ERR_STICKY=2'b01, readback yields 0x1..0x10 with no 0xDEAD.
- Read on an empty FIFO -> BUF_UNDER pulse, FIFOVALID=0, COUNT stays 0, ERR_STICKY[1]=1. Then ERR_CLR -> ERR_STICKY=0.
- Simultaneous FIFOWR+FIFORD at COUNT=5 for 40 cycles -> COUNT stays 5, data order preserved across pointer wrap, FIFOVALID=1 every cycle.
- FIFORST at COUNT=10 with FIFOWR=1 in the same cycle -> next cycle COUNT=0, EMPTY=1, no BUF_OVER, ERR_STICKY unchanged.
- ARST asserted mid-burst, asynchronous to ACLK -> all outputs at reset values immediately, including ERR_STICKY=0; the first write after release is read back correctly.
